// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch-stage definitions: default widths and the
// {addr, word} layout of a buffered fetch entry.
package fetch_prefetch_queue_pkg;

  localparam int FQ_ADDR_W = 16;
  localparam int FQ_DATA_W = 16;
  localparam int FQ_DEPTH  = 4;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] addr;
    logic [FQ_DATA_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with clear; head is read straight
// from the storage flops so the output is registered.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Credit upstream must never let a push land on a full queue.
  assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: issues imem reads under credit, tags them with
// their PC, buffers returned words and drops stale ones on flush.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int ADDR_W = FQ_ADDR_W,
  parameter int DATA_W = FQ_DATA_W,
  parameter int DEPTH  = FQ_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
  } entry_t;

  entry_t            wr_entry, head;
  logic [ADDR_W-1:0] tag_head;
  logic [CW-1:0]     count, tag_count;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW:0]       inflight;
  logic              issue, keep, pop;
  logic              data_empty, data_full;
  logic              tag_full, tag_empty;
  logic              unused_sigs;

  assign inflight  = {1'b0, count} + {1'b0, outstanding_q};
  assign imem_req  = !reset && !flush
                   && (inflight < (CW+1)'(DEPTH));
  assign imem_addr = pc_addr;
  assign issue     = imem_req && imem_gnt;
  assign pc_en     = issue || (flush && !reset);
  assign keep      = imem_rvalid && (drop_q == '0) && !flush;
  assign pop       = inst_valid && inst_ready && !flush;

  assign inst_valid = !data_empty;
  assign wr_entry   = '{addr: tag_head, word: imem_rdata};
  assign inst       = head.word;
  assign inst_pc    = head.addr;

  assign unused_sigs = ^{tag_count, tag_full, tag_empty, data_full};

  // Dropped words are still in flight, so they keep consuming credit.
  always_comb begin
    outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
    drop_d        = drop_q;
    if (flush) begin
      drop_d = outstanding_q - CW'(imem_rvalid);
    end else if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (issue),
    .pop   (keep),
    .wdata (pc_addr),
    .rdata (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_data_q (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (keep),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (data_full),
    .empty (data_empty)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus a random
// run against a queue-based model of fetches and buffered words.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] pc_addr = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        inst_ready = 1'b0;
  logic        pc_en, imem_req, inst_valid;
  logic [15:0] imem_addr, inst, inst_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] addr;
    bit          drop;
  } fl_t;

  logic [15:0] pc_m = '0;
  logic [15:0] tgt = '0;
  bit          hold = 1'b0;
  logic [15:0] memq[$];
  fl_t         infl[$];
  logic [15:0] outq[$];

  always #5 clk = ~clk;

  fetch_prefetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .pc_addr    (pc_addr),
    .pc_en      (pc_en),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  function automatic logic [15:0] wfn(input logic [15:0] a);
    return (a * 16'd37) ^ 16'hC35A;
  endfunction

  function automatic bit exp_req();
    return !reset && !flush && (outq.size() + infl.size() < DEPTH);
  endfunction

  task automatic setup(input bit r, input bit f, input bit g,
                       input bit rdy, input bit h,
                       input logic [15:0] t);
    @(negedge clk);
    reset      = r;
    flush      = f;
    imem_gnt   = g;
    inst_ready = rdy;
    hold       = h;
    tgt        = t;
    pc_addr    = pc_m;
    imem_rvalid = !r && !h && (memq.size() > 0);
    imem_rdata  = imem_rvalid ? wfn(memq[0]) : 16'h0BAD;
    #1;
  endtask

  task automatic tick();
    bit          er, iss, rv;
    logic [15:0] ia, a;
    fl_t         e;
    er  = exp_req();
    iss = imem_req && imem_gnt;
    rv  = imem_rvalid;
    ia  = imem_addr;
    @(posedge clk);
    if (reset) begin
      memq.delete();
    end else begin
      if (rv && memq.size() > 0) a = memq.pop_front();
      if (iss) memq.push_back(ia);
    end
    if (reset) begin
      infl.delete();
      outq.delete();
    end else if (flush) begin
      outq.delete();
      foreach (infl[i]) infl[i].drop = 1'b1;
      if (rv && infl.size() > 0) e = infl.pop_front();
      pc_m = tgt;
    end else begin
      if (outq.size() > 0 && inst_ready) a = outq.pop_front();
      if (rv && infl.size() > 0) begin
        e = infl.pop_front();
        if (!e.drop) outq.push_back(e.addr);
      end
      if (er && imem_gnt) begin
        infl.push_back('{pc_m, 1'b0});
        pc_m = pc_m + 16'd1;
      end
    end
  endtask

  task automatic do_reset();
    setup(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    tick();
    pc_m = '0;
  endtask

  task automatic test_reset();
    setup(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++;
    if (imem_req !== 1'b0 || pc_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl req=%b pc_en=%b want 0 0", imem_req, pc_en);
    end
    tick();
    pc_m = '0;
    setup(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checks++;
    if (inst_valid !== 1'b0 || inst !== 16'h0 || inst_pc !== 16'h0) begin
      failures++;
      $display("FAIL reset_out valid=%b inst=%h pc=%h want 0 0 0",
               inst_valid, inst, inst_pc);
    end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_credit req=%b want 1", imem_req);
    end
    tick();
  endtask

  task automatic test_stream();
    bit          ev;
    logic [15:0] ep;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      ev = (i >= 2);
      ep = 16'(i - 2);
      checks++;
      if (pc_en !== 1'b1) begin
        failures++;
        $display("FAIL stream_pc_en cyc=%0d got=%b want 1", i, pc_en);
      end
      checks++;
      if (inst_valid !== ev || (ev && (inst_pc !== ep || inst !== wfn(ep)))) begin
        failures++;
        $display("FAIL stream_out cyc=%0d valid=%b pc=%h inst=%h want %b %h %h",
                 i, inst_valid, inst_pc, inst, ev, ep, wfn(ep));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    int got  = 0;
    bit last_req, last_en;
    bit seen = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      setup(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      if (imem_req) nreq++;
      last_req = imem_req;
      last_en  = pc_en;
      tick();
    end
    checks++;
    if (nreq != 4 || last_req !== 1'b0 || last_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_fill reqs=%0d req=%b pc_en=%b want 4 0 0",
               nreq, last_req, last_en);
    end
    for (int i = 0; i < 20; i++) begin
      setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      if (inst_valid && got < 4) begin
        checks++;
        if (inst_pc !== 16'(got) || inst !== wfn(16'(got))) begin
          failures++;
          $display("FAIL stall_order idx=%0d pc=%h inst=%h want %h %h",
                   got, inst_pc, inst, 16'(got), wfn(16'(got)));
        end
        got++;
      end
      if (imem_req && imem_gnt && !seen) begin
        seen = 1'b1;
        checks++;
        if (imem_addr !== 16'h0004) begin
          failures++;
          $display("FAIL stall_resume addr=%h want 0004", imem_addr);
        end
      end
      tick();
    end
    checks++;
    if (got != 4 || !seen) begin
      failures++;
      $display("FAIL stall_drain popped=%0d resumed=%b want 4 1", got, seen);
    end
  endtask

  task automatic test_flush();
    bit found = 1'b0;
    do_reset();
    setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    tick();
    setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    tick();
    setup(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0040);
    checks++;
    if (imem_req !== 1'b0 || pc_en !== 1'b1) begin
      failures++;
      $display("FAIL flush_ctrl req=%b pc_en=%b want 0 1", imem_req, pc_en);
    end
    tick();
    for (int i = 0; i < 12; i++) begin
      setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      if (i == 0) begin
        checks++;
        if (inst_valid !== 1'b0) begin
          failures++;
          $display("FAIL flush_valid got=%b want 0", inst_valid);
        end
      end
      if (inst_valid && !found) begin
        found = 1'b1;
        checks++;
        if (inst_pc !== 16'h0040 || inst !== wfn(16'h0040)) begin
          failures++;
          $display("FAIL flush_target pc=%h inst=%h want 0040 %h",
                   inst_pc, inst, wfn(16'h0040));
        end
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL flush_timeout got=none want inst at 0040");
    end
  endtask

  task automatic test_flush_rvalid();
    bit          ev;
    logic [15:0] ep;
    do_reset();
    setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    tick();
    setup(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0080);
    tick();
    for (int i = 0; i < 6; i++) begin
      setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      ev = (i >= 2);
      ep = 16'h0080 + 16'(i - 2);
      checks++;
      if (inst_valid !== ev || (ev && (inst_pc !== ep || inst !== wfn(ep)))) begin
        failures++;
        $display("FAIL flush_rv cyc=%0d valid=%b pc=%h want %b %h",
                 i, inst_valid, inst_pc, ev, ep);
      end
      tick();
    end
  endtask

  task automatic test_gnt_hold();
    logic [15:0] a;
    do_reset();
    a = pc_m;
    for (int i = 0; i < 3; i++) begin
      setup(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      checks++;
      if (imem_req !== 1'b1 || pc_en !== 1'b0 || imem_addr !== a) begin
        failures++;
        $display("FAIL gnt_hold cyc=%0d req=%b pc_en=%b addr=%h want 1 0 %h",
                 i, imem_req, pc_en, imem_addr, a);
      end
      tick();
    end
    setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checks++;
    if (pc_en !== 1'b1 || imem_addr !== a) begin
      failures++;
      $display("FAIL gnt_accept pc_en=%b addr=%h want 1 %h", pc_en, imem_addr, a);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] base;
    bit          found = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      setup(1'b0, 1'b0, 1'b1, 1'b0, (i >= 3), 16'h0);
      tick();
    end
    setup(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0077);
    checks++;
    if (imem_req !== 1'b0 || pc_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl req=%b pc_en=%b want 0 0", imem_req, pc_en);
    end
    tick();
    base = pc_m;
    for (int i = 0; i < 10; i++) begin
      setup(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      if (i == 0) begin
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin
          failures++;
          $display("FAIL rst_mid_state valid=%b req=%b want 0 1",
                   inst_valid, imem_req);
        end
      end
      if (inst_valid && !found) begin
        found = 1'b1;
        checks++;
        if (inst_pc !== base) begin
          failures++;
          $display("FAIL rst_mid_restart pc=%h want %h", inst_pc, base);
        end
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_mid_timeout got=none want inst at %h", base);
    end
  endtask

  task automatic test_random();
    bit er, ee, ev;
    bit r, f, g, rdy, h;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      f   = ($urandom_range(0, 15) == 0);
      g   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      h   = ($urandom_range(0, 2) == 0);
      setup(r, f, g, rdy, h, 16'($urandom));
      er = exp_req();
      ee = !reset && ((er && imem_gnt) || flush);
      checks++;
      if (imem_req !== er || pc_en !== ee || imem_addr !== pc_m) begin
        failures++;
        $display("FAIL rand_ctrl n=%0d req=%b pc_en=%b addr=%h want %b %b %h",
                 n, imem_req, pc_en, imem_addr, er, ee, pc_m);
      end
      ev = (outq.size() > 0);
      checks++;
      if (inst_valid !== ev ||
          (ev && (inst_pc !== outq[0] || inst !== wfn(outq[0])))) begin
        failures++;
        $display("FAIL rand_head n=%0d valid=%b pc=%h inst=%h want %b %h",
                 n, inst_valid, inst_pc, inst, ev, ev ? outq[0] : 16'h0);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_rvalid();
    test_gnt_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
